bp_cce_cfg_link_responder: RTL and testbench
============================================

Name: bp_cce_cfg_link_responder

Overview:
- Target end of the CCE config link.
- Accepts config-channel write and read transactions from a cfg loader or host.
- Assembles pairs of lo/hi link words into full CCE instructions and writes them into the instruction RAM.
- Serves readback of instruction halves and a small control/status register file (CCE mode, commit count, sticky error).
- Sits beside the CCE, between the config link and the instruction RAM write/read port.

Parameters:
- inst_width_p, 48: CCE instruction width. Required: cfg_link_data_width_p < inst_width_p <= 2*cfg_link_data_width_p.
- inst_ram_addr_width_p, 8: instruction RAM index width.
- cfg_link_addr_width_p, 16: config link address width. The channel carries cfg_link_addr_width_p-1 bits.
- cfg_link_data_width_p, 32: config link data width.
- Derived (localparam) hi_w = inst_width_p-cfg_link_data_width_p: width of the instruction hi half.
- Derived (localparam) A = cfg_link_addr_width_p-1: channel address width.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous active-high reset
- config_addr_i  in  A  transaction address
- config_data_i  in  cfg_link_data_width_p  write data
- config_v_i  in  1  request valid
- config_w_i  in  1  1=write, 0=read
- config_ready_o  out  1  request accept
- config_data_o  out  cfg_link_data_width_p  read response data
- config_v_o  out  1  read response valid
- config_ready_i  in  1  response consumer ready
- inst_ram_v_o  out  1  RAM access valid
- inst_ram_w_o  out  1  RAM write enable
- inst_ram_addr_o  out  inst_ram_addr_width_p  RAM index
- inst_ram_data_o  out  inst_width_p  RAM write data
- inst_ram_data_i  in  inst_width_p  RAM read data, valid 1 cycle after a read
- cce_mode_o  out  1  CCE mode register (0=normal, 1=uncached)

Behaviour:
- Address decode:
  - addr[A-1]=0 selects RAM space: addr[0]=half (0 lo, 1 hi), addr[1+:inst_ram_addr_width_p]=index.
  - addr[A-1]=1 selects register space, with addr[1:0] as register number:
    - 0: cce_mode, R/W, bit 0 only.
    - 1: commit_cnt, RO, 16 bits zero-extended.
    - 2: err, R/W1C, bit 0.
    - 3: reads 0, writes ignored.
- Request handshake: a request is accepted when config_v_i & config_ready_o. config_ready_o=1 only in state READY.
- FSM states READY, RD_WAIT, RESP.
- READY, write accepted: handled in the same cycle, no response, stays READY.
  - Lo write: hold_data<=data, hold_idx<=index, hold_v<=1.
  - Hi write: combinationally drive inst_ram_v_o=inst_ram_w_o=1, inst_ram_addr_o=index, inst_ram_data_o={data[hi_w-1:0], lo}.
    - lo=hold_data if hold_v & hold_idx==index; else lo=0 and err<=1.
    - hold_v<=0.
    - commit_cnt<=commit_cnt+1, saturating at 16'hFFFF.
  - Register write: update the addressed register. Writing 1 to err bit 0 clears it.
- READY, read accepted:
  - RAM space: drive inst_ram_v_o=1, inst_ram_w_o=0, inst_ram_addr_o=index; go to RD_WAIT. Latch the half bit.
  - Register space: capture the register value into resp_r; go to RESP.
- RD_WAIT: capture resp_r.
  - Lo half: inst_ram_data_i[cfg_link_data_width_p-1:0].
  - Hi half: zero-extended inst_ram_data_i[inst_width_p-1 -: hi_w].
  - Go to RESP.
- RESP: config_v_o=1, config_data_o=resp_r. Hold both stable until config_ready_i, then go to READY. Earliest next request is accepted the following cycle.
- Read latency:
  - RAM space: response valid 2 cycles after accept.
  - Register space: response valid 1 cycle after accept.
- Outputs outside the cases above: inst_ram_* = 0, config_v_o=0, config_data_o=0.
- Reset (asynchronous, any state, including mid-read):
  - State goes to READY.
  - hold_v, hold_data, commit_cnt, err, cce_mode, resp_r all cleared.
  - Outputs: config_ready_o=0 while reset_i is high, then 1 in READY. config_v_o=0, inst_ram_v_o=0, cce_mode_o=0.
  - A pending response is dropped.
- Boundary conditions:
  - Consecutive lo writes: the last one wins.
  - A lo write to a different index overwrites the holding register.
  - Hi write to index 2^inst_ram_addr_width_p-1 is legal; there is no wrap logic.
  - Register-space write while hold_v=1 leaves the holding register intact.
  - Reads never disturb the holding register.

Optional Feature:
- Macro: BP_CCE_CFG_LINK_READBACK_EN.
- Defined: RAM-space reads behave as above.
- Undefined:
  - RAM-space reads never drive inst_ram_v_o.
  - They go straight to RESP with resp_r=0 (1-cycle latency).
  - RD_WAIT is removed, and inst_ram_data_i is unused.

Test Plan:
- Lo write 0x89ABCDEF, then hi write 0x1234, both to index 5 -> one RAM write at index 5, data 48'h1234_89ABCDEF; commit_cnt=1; err=0.
- Hi write 0x55AA to index 7 with no prior lo write -> RAM data 48'h55AA_00000000; err reads 1; W1C write 1 to reg 2 -> err reads 0.
- After the first test, read index 5 lo and then index 5 hi with config_ready_i=1 -> responses 0x89ABCDEF and 0x00001234, each 2 cycles after accept (readback enabled).
- Read reg 0 with config_ready_i held 0 for 4 cycles -> config_v_o stays 1 with stable data and config_ready_o=0 throughout; completes on the cycle config_ready_i rises.
- Write cce_mode=1 -> cce_mode_o=1 the next cycle. Assert reset_i asynchronously mid-RD_WAIT -> config_v_o and cce_mode_o go 0 immediately; no response is issued after reset.
- Stream 2*256 alternating lo/hi writes back to back (loader pattern) -> 256 RAM writes, commit_cnt=256, config_ready_o=1 on every cycle.

Source files
------------

// File: rtl/bp_cce_cfg_link_responder.sv
// bp_cce_cfg_link_responder
//   Target end of the CCE config link. It accepts write/read transactions,
//   pairs lo/hi link words into full CCE instructions written to the
//   instruction RAM, and serves readback of instruction halves plus a small
//   register file (cce_mode, commit_cnt, sticky err).
//
// Ports
//   clk_i, reset_i            clock, asynchronous active-high reset
//   config_addr_i/data_i      request address and write data
//   config_v_i/w_i            request valid, 1=write 0=read
//   config_ready_o            request accept (READY state only)
//   config_data_o/v_o         read response data/valid
//   config_ready_i            response consumer ready
//   inst_ram_v_o/w_o          RAM access valid / write enable
//   inst_ram_addr_o/data_o    RAM index / write data
//   inst_ram_data_i           RAM read data, valid one cycle after a read
//   cce_mode_o                CCE mode register (0 normal, 1 uncached)
//
// Build option
//   BP_CCE_CFG_LINK_READBACK_EN: when defined, RAM-space reads fetch the
//   instruction half from RAM (2-cycle latency). When undefined, RAM-space
//   reads return 0 after 1 cycle and never touch the RAM.

module bp_cce_cfg_link_responder #(
   parameter int inst_width_p          = 48,
   parameter int inst_ram_addr_width_p = 8,
   parameter int cfg_link_addr_width_p = 16,
   parameter int cfg_link_data_width_p = 32
) (
   input  logic                             clk_i,
   input  logic                             reset_i,
   input  logic [cfg_link_addr_width_p-2:0] config_addr_i,
   input  logic [cfg_link_data_width_p-1:0] config_data_i,
   input  logic                             config_v_i,
   input  logic                             config_w_i,
   output logic                             config_ready_o,
   output logic [cfg_link_data_width_p-1:0] config_data_o,
   output logic                             config_v_o,
   input  logic                             config_ready_i,
   output logic                             inst_ram_v_o,
   output logic                             inst_ram_w_o,
   output logic [inst_ram_addr_width_p-1:0] inst_ram_addr_o,
   output logic [inst_width_p-1:0]          inst_ram_data_o,
   input  logic [inst_width_p-1:0]          inst_ram_data_i,
   output logic                             cce_mode_o
);

   localparam int hi_w = inst_width_p - cfg_link_data_width_p;
   localparam int A    = cfg_link_addr_width_p - 1;
   localparam int D    = cfg_link_data_width_p;
   localparam int IW   = inst_ram_addr_width_p;

`ifdef BP_CCE_CFG_LINK_READBACK_EN
   typedef enum logic [1:0] {READY, RD_WAIT, RESP} state_t;
`else
   typedef enum logic [1:0] {READY, RESP} state_t;
`endif

   state_t state, state_n;

   logic [D-1:0]  hold_data;
   logic [IW-1:0] hold_idx;
   logic          hold_v;
   logic [15:0]   commit_cnt;
   logic          err;
   logic          cce_mode;
   logic [D-1:0]  resp_r;

   // Address decode
   logic          space_reg;
   logic          half;
   logic [IW-1:0] idx;
   logic [1:0]    reg_sel;

   assign space_reg = config_addr_i[A-1];
   assign half      = config_addr_i[0];
   assign idx       = config_addr_i[1 +: IW];
   assign reg_sel   = config_addr_i[1:0];

   logic accept, wr_acc, rd_acc;
   logic lo_wr, hi_wr, reg_wr;
   logic lo_match;

   assign accept   = config_v_i & config_ready_o;
   assign wr_acc   = accept & config_w_i;
   assign rd_acc   = accept & ~config_w_i;
   assign lo_wr    = wr_acc & ~space_reg & ~half;
   assign hi_wr    = wr_acc & ~space_reg & half;
   assign reg_wr   = wr_acc & space_reg;
   assign lo_match = hold_v & (hold_idx == idx);

   // Register-space read value
   logic [D-1:0] reg_rd_val;

   always_comb begin
      reg_rd_val = '0;
      case (reg_sel)
         2'd0:    reg_rd_val[0]    = cce_mode;
         2'd1:    reg_rd_val[15:0] = commit_cnt;
         2'd2:    reg_rd_val[0]    = err;
         default: reg_rd_val       = '0;
      endcase
   end

`ifdef BP_CCE_CFG_LINK_READBACK_EN
   logic         half_r;
   logic [D-1:0] ram_hi_ext;
   logic [D-1:0] ram_lo;

   always_comb begin
      ram_hi_ext           = '0;
      ram_hi_ext[hi_w-1:0] = inst_ram_data_i[inst_width_p-1 -: hi_w];
   end
   assign ram_lo = inst_ram_data_i[D-1:0];

   logic unused_bits;
   assign unused_bits = ^config_addr_i;
`else
   logic unused_bits;
   assign unused_bits = ^{config_addr_i, inst_ram_data_i};
`endif

   // Next state and outputs
   always_comb begin
      state_n         = state;
      config_ready_o  = 1'b0;
      config_v_o      = 1'b0;
      config_data_o   = '0;
      inst_ram_v_o    = 1'b0;
      inst_ram_w_o    = 1'b0;
      inst_ram_addr_o = '0;
      inst_ram_data_o = '0;

      case (state)
         READY: begin
            config_ready_o = ~reset_i;
            if (hi_wr) begin
               inst_ram_v_o    = 1'b1;
               inst_ram_w_o    = 1'b1;
               inst_ram_addr_o = idx;
               // Missing or mismatched lo half is committed as zero and flagged.
               inst_ram_data_o = {config_data_i[hi_w-1:0],
                                  (lo_match ? hold_data : {D{1'b0}})};
            end
            if (rd_acc) begin
               if (space_reg) begin
                  state_n = RESP;
               end else begin
`ifdef BP_CCE_CFG_LINK_READBACK_EN
                  inst_ram_v_o    = 1'b1;
                  inst_ram_addr_o = idx;
                  state_n         = RD_WAIT;
`else
                  state_n = RESP;
`endif
               end
            end
         end
`ifdef BP_CCE_CFG_LINK_READBACK_EN
         RD_WAIT: begin
            state_n = RESP;
         end
`endif
         RESP: begin
            config_v_o    = 1'b1;
            config_data_o = resp_r;
            if (config_ready_i) state_n = READY;
         end
         default: begin
            state_n = READY;
         end
      endcase
   end

   // State and register file
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state      <= READY;
         hold_v     <= 1'b0;
         hold_data  <= '0;
         hold_idx   <= '0;
         commit_cnt <= '0;
         err        <= 1'b0;
         cce_mode   <= 1'b0;
         resp_r     <= '0;
`ifdef BP_CCE_CFG_LINK_READBACK_EN
         half_r     <= 1'b0;
`endif
      end else begin
         state <= state_n;

         if (lo_wr) begin
            hold_data <= config_data_i;
            hold_idx  <= idx;
            hold_v    <= 1'b1;
         end else if (hi_wr) begin
            hold_v <= 1'b0;
         end

         if (hi_wr && (commit_cnt != 16'hFFFF))
            commit_cnt <= commit_cnt + 16'd1;

         if (hi_wr && !lo_match)
            err <= 1'b1;
         else if (reg_wr && (reg_sel == 2'd2) && config_data_i[0])
            err <= 1'b0;

         if (reg_wr && (reg_sel == 2'd0))
            cce_mode <= config_data_i[0];

         if (rd_acc)
            resp_r <= space_reg ? reg_rd_val : '0;

`ifdef BP_CCE_CFG_LINK_READBACK_EN
         if (rd_acc)
            half_r <= half;
         if (state == RD_WAIT)
            resp_r <= half_r ? ram_hi_ext : ram_lo;
`endif
      end
   end

   assign cce_mode_o = cce_mode;

endmodule

// File: tb/tb_bp_cce_cfg_link_responder.sv
// Testbench for bp_cce_cfg_link_responder: table-driven transactions plus
// directed sequences for response back-pressure, asynchronous reset during a
// read, and a back-to-back loader stream.

module tb_bp_cce_cfg_link_responder;

`ifdef BP_CCE_CFG_LINK_READBACK_EN
   localparam bit RB = 1'b1;
`else
   localparam bit RB = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic [14:0] config_addr;
   logic [31:0] config_data_in;
   logic        config_v_in;
   logic        config_w;
   logic        config_ready_out;
   logic [31:0] config_data_out;
   logic        config_v_out;
   logic        config_ready_in;
   logic        ram_v;
   logic        ram_w;
   logic [7:0]  ram_addr;
   logic [47:0] ram_wdata;
   logic [47:0] ram_rdata;
   logic        cce_mode;

   bp_cce_cfg_link_responder #(
      .inst_width_p(48),
      .inst_ram_addr_width_p(8),
      .cfg_link_addr_width_p(16),
      .cfg_link_data_width_p(32)
   ) dut (
      .clk_i(clk),
      .reset_i(reset),
      .config_addr_i(config_addr),
      .config_data_i(config_data_in),
      .config_v_i(config_v_in),
      .config_w_i(config_w),
      .config_ready_o(config_ready_out),
      .config_data_o(config_data_out),
      .config_v_o(config_v_out),
      .config_ready_i(config_ready_in),
      .inst_ram_v_o(ram_v),
      .inst_ram_w_o(ram_w),
      .inst_ram_addr_o(ram_addr),
      .inst_ram_data_o(ram_wdata),
      .inst_ram_data_i(ram_rdata),
      .cce_mode_o(cce_mode)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction RAM model: synchronous read, one cycle latency.
   logic [47:0] mem [256];
   int          ram_wr_cnt = 0;

   always @(posedge clk) begin
      if (ram_v) begin
         if (ram_w) begin
            mem[ram_addr] <= ram_wdata;
            ram_wr_cnt    <= ram_wr_cnt + 1;
         end else begin
            ram_rdata <= mem[ram_addr];
         end
      end
   end

   int tests  = 0;
   int failed = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      bit          is_wr;
      logic [14:0] addr;
      logic [31:0] data;
      bit          exp_wr;
      logic [7:0]  exp_idx;
      logic [47:0] exp_ram;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mkw(logic [14:0] a, logic [31:0] d, bit ew,
                                logic [7:0] ei, logic [47:0] er);
      vec_t v;
      v.is_wr = 1'b1; v.addr = a; v.data = d;
      v.exp_wr = ew; v.exp_idx = ei; v.exp_ram = er; v.exp_rd = '0;
      return v;
   endfunction

   function automatic vec_t mkr(logic [14:0] a, logic [31:0] e);
      vec_t v;
      v.is_wr = 1'b0; v.addr = a; v.data = '0;
      v.exp_wr = 1'b0; v.exp_idx = '0; v.exp_ram = '0; v.exp_rd = e;
      return v;
   endfunction

   task automatic do_write(input logic [14:0] a, input logic [31:0] d, input bit ew,
                           input logic [7:0] ei, input logic [47:0] er, input string name);
      @(negedge clk);
      config_v_in = 1'b1; config_w = 1'b1; config_addr = a; config_data_in = d;
      #1;
      chk({name, ".ready"}, config_ready_out, 1'b1);
      chk({name, ".ram_v"}, ram_v, ew);
      if (ew) begin
         chk({name, ".ram_w"}, ram_w, 1'b1);
         chk({name, ".ram_addr"}, ram_addr, ei);
         chk({name, ".ram_data"}, ram_wdata, er);
      end
      @(posedge clk);
      #1 config_v_in = 1'b0;
   endtask

   task automatic do_read(input logic [14:0] a, input logic [31:0] e, input string name);
      bit ram_space;
      int lat;
      ram_space = ~a[14];
      @(negedge clk);
      config_v_in = 1'b1; config_w = 1'b0; config_addr = a;
      #1;
      chk({name, ".ready"}, config_ready_out, 1'b1);
      chk({name, ".ram_v"}, ram_v, ram_space && RB);
      @(posedge clk);
      #1 config_v_in = 1'b0;
      lat = 1;
      @(negedge clk);
      while (config_v_out !== 1'b1 && lat < 10) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      chk({name, ".latency"}, lat, (ram_space && RB) ? 2 : 1);
      chk({name, ".data"}, config_data_out, e);
      @(posedge clk);
      #1;
      chk({name, ".done"}, config_v_out, 1'b0);
   endtask

   initial begin
      int n_hi;
      int not_ready;
      int w0;
      logic [14:0] a;
      logic [7:0]  i8;

      reset = 1'b1;
      config_addr = '0; config_data_in = '0; config_v_in = 1'b0;
      config_w = 1'b0; config_ready_in = 1'b1;
      #3;
      chk("rst.ready", config_ready_out, 1'b0);
      chk("rst.v_out", config_v_out, 1'b0);
      chk("rst.ram_v", ram_v, 1'b0);
      chk("rst.mode", cce_mode, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b0;
      #1 chk("rst.ready_after", config_ready_out, 1'b1);

      // Transaction table
      vecs.push_back(mkw(15'h000A, 32'h89ABCDEF, 0, 8'd0, 48'h0));
      vecs.push_back(mkw(15'h000B, 32'h00001234, 1, 8'd5, 48'h1234_89ABCDEF));
      vecs.push_back(mkr(15'h4001, 32'd1));
      vecs.push_back(mkr(15'h4002, 32'd0));
      vecs.push_back(mkw(15'h000F, 32'h000055AA, 1, 8'd7, 48'h55AA_00000000));
      vecs.push_back(mkr(15'h4002, 32'd1));
      vecs.push_back(mkw(15'h4002, 32'd1, 0, 8'd0, 48'h0));
      vecs.push_back(mkr(15'h4002, 32'd0));
      vecs.push_back(mkr(15'h000A, RB ? 32'h89ABCDEF : 32'h0));
      vecs.push_back(mkr(15'h000B, RB ? 32'h00001234 : 32'h0));
      vecs.push_back(mkr(15'h4001, 32'd2));
      // last lo wins; register write and read keep the holding register
      vecs.push_back(mkw(15'h0006, 32'h11111111, 0, 8'd0, 48'h0));
      vecs.push_back(mkw(15'h0006, 32'h22222222, 0, 8'd0, 48'h0));
      vecs.push_back(mkw(15'h4000, 32'd0, 0, 8'd0, 48'h0));
      vecs.push_back(mkr(15'h4003, 32'd0));
      vecs.push_back(mkw(15'h0007, 32'hFFFFABCD, 1, 8'd3, 48'hABCD_22222222));
      vecs.push_back(mkr(15'h4002, 32'd0));
      // lo to a different index replaces the held word
      vecs.push_back(mkw(15'h0012, 32'h33333333, 0, 8'd0, 48'h0));
      vecs.push_back(mkw(15'h0014, 32'h44444444, 0, 8'd0, 48'h0));
      vecs.push_back(mkw(15'h0013, 32'h00000001, 1, 8'd9, 48'h0001_00000000));
      vecs.push_back(mkr(15'h4002, 32'd1));
      vecs.push_back(mkw(15'h4002, 32'd0, 0, 8'd0, 48'h0));
      vecs.push_back(mkr(15'h4002, 32'd1));
      vecs.push_back(mkw(15'h4002, 32'd1, 0, 8'd0, 48'h0));
      // top index
      vecs.push_back(mkw(15'h01FE, 32'hCAFEF00D, 0, 8'd0, 48'h0));
      vecs.push_back(mkw(15'h01FF, 32'h0000BEEF, 1, 8'd255, 48'hBEEF_CAFEF00D));
      vecs.push_back(mkr(15'h4002, 32'd0));
      vecs.push_back(mkr(15'h01FF, RB ? 32'h0000BEEF : 32'h0));
      vecs.push_back(mkr(15'h4001, 32'd5));
      // read-only and reserved registers
      vecs.push_back(mkw(15'h4001, 32'd0, 0, 8'd0, 48'h0));
      vecs.push_back(mkr(15'h4001, 32'd5));
      vecs.push_back(mkw(15'h4003, 32'hFFFFFFFF, 0, 8'd0, 48'h0));
      vecs.push_back(mkr(15'h4003, 32'd0));
      vecs.push_back(mkr(15'h4000, 32'd0));
      vecs.push_back(mkw(15'h4000, 32'hFFFFFFFF, 0, 8'd0, 48'h0));
      vecs.push_back(mkr(15'h4000, 32'd1));

      for (int k = 0; k < vecs.size(); k++) begin
         string nm;
         nm = $sformatf("vec%0d", k);
         if (vecs[k].is_wr)
            do_write(vecs[k].addr, vecs[k].data, vecs[k].exp_wr,
                     vecs[k].exp_idx, vecs[k].exp_ram, nm);
         else
            do_read(vecs[k].addr, vecs[k].exp_rd, nm);
      end

      // Response back-pressure: cce_mode is 1 from the table
      config_ready_in = 1'b0;
      @(negedge clk);
      config_v_in = 1'b1; config_w = 1'b0; config_addr = 15'h4000;
      @(posedge clk);
      #1 config_v_in = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk($sformatf("bp%0d.v_out", c), config_v_out, 1'b1);
         chk($sformatf("bp%0d.data", c), config_data_out, 32'd1);
         chk($sformatf("bp%0d.ready", c), config_ready_out, 1'b0);
      end
      config_ready_in = 1'b1;
      @(posedge clk);
      #1;
      chk("bp.done_v", config_v_out, 1'b0);
      chk("bp.done_ready", config_ready_out, 1'b1);

      // Asynchronous reset during a RAM read
      do_write(15'h4000, 32'd1, 0, 8'd0, 48'h0, "mode_set");
      chk("mode_set.mode", cce_mode, 1'b1);
      @(negedge clk);
      config_v_in = 1'b1; config_w = 1'b0; config_addr = 15'h000A;
      @(posedge clk);
      #1 config_v_in = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("arst.v_out", config_v_out, 1'b0);
      chk("arst.mode", cce_mode, 1'b0);
      chk("arst.ready", config_ready_out, 1'b0);
      chk("arst.ram_v", ram_v, 1'b0);
      @(negedge clk) reset = 1'b0;
      #1 chk("arst.ready_after", config_ready_out, 1'b1);
      n_hi = 0;
      repeat (4) begin
         @(negedge clk);
         if (config_v_out) n_hi++;
      end
      chk("arst.no_resp", n_hi, 0);
      do_read(15'h4001, 32'd0, "arst.commit");

      // Loader stream: 256 lo/hi pairs back to back
      not_ready = 0;
      w0 = ram_wr_cnt;
      for (int i = 0; i < 256; i++) begin
         for (int h = 0; h < 2; h++) begin
            i8 = i[7:0];
            a = '0;
            a[8:1] = i8;
            a[0] = h[0];
            @(negedge clk);
            config_v_in = 1'b1; config_w = 1'b1; config_addr = a;
            config_data_in = h[0] ? {16'h0, 16'h5A5A ^ {8'h0, i8}} : {24'hA50000, i8};
            #1;
            if (config_ready_out !== 1'b1) not_ready++;
         end
      end
      @(negedge clk) config_v_in = 1'b0;
      @(posedge clk);
      #1;
      chk("stream.ready_every_cycle", not_ready, 0);
      chk("stream.ram_writes", ram_wr_cnt - w0, 256);
      chk("stream.mem200", mem[200], 48'h5A92_A50000C8);
      chk("stream.mem0", mem[0], 48'h5A5A_A5000000);
      do_read(15'h4001, 32'd256, "stream.commit");
      do_read(15'h4002, 32'd0, "stream.err");

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got no finish expected finish");
      $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
      $fatal(1);
   end

endmodule
